ir_tx_scheduler: RTL and testbench

IR_TX_SCHEDULER -- requirements
Module: ir_tx_scheduler

---
 rtl/ir_tx_scheduler.sv | 128 ++++++++++++
 tb/tb_ir_tx_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: 4-entry NEC command queue that builds 32-bit frames and paces
// tx_start against tx_busy, enforcing a fixed idle gap after every frame.
module ir_tx_scheduler #(
    parameter int unsigned GAP_CYCLES   = 1000,
    parameter int unsigned BUSY_TIMEOUT = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_code,
    output logic [31:0] tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [2:0]  fifo_level,
    output logic        err_timeout,
    output logic        idle
);
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned CNT_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    // One counter serves both WAIT_BUSY and GAP; it only ever counts to CNT_MAX-1.
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SENDING,
        GAP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    assign cmd_ready = (fifo_level < 3'(DEPTH)) && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_level != 3'd0) && !tx_busy;
    assign idle      = (state == IDLE) && (fifo_level == 3'd0);
    assign head      = mem[rd_ptr];

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_addr, cmd_code};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 3'd1;
                2'b01:   fifo_level <= fifo_level - 3'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Frame sequencer; tx_start and err_timeout are single-cycle registered strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= {~head[7:0], head[7:0], ~head[15:8], head[15:8]};
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= SENDING;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SENDING: begin
                    if (!tx_busy) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Bench for ir_tx_scheduler: directed scenarios plus random traffic, checked every
// cycle against a timestamp/queue model of the scheduling rules.
module tb_ir_tx_scheduler;
    localparam int GAP = 8;
    localparam int BT  = 16;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_code;
    logic [31:0] tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [2:0]  fifo_level;
    logic        err_timeout;
    logic        idle;

    ir_tx_scheduler #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_code(cmd_code), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .fifo_level(fifo_level), .err_timeout(err_timeout), .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Model state: queued commands plus the timestamps that govern the next start.
    logic [15:0] q[$];
    logic [31:0] last_frame;
    int  t;
    int  earliest;
    int  s0;
    bit  inflight;
    bit  seen_busy;
    bit  start_exp;
    bit  to_exp;
    int  busy_mode;       // 0: never busy, 1: pulse after each start, 2: held high
    int  busy_d;
    int  busy_l;
    int  rise;
    int  fall;
    bit  prev_idle;

    int fall_edges[$];
    int dut_start_edges[$];
    int dut_err_edges[$];
    int dut_idle_rise[$];
    logic [31:0] dut_frames[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [31:0] frame(input logic [15:0] e);
        logic [7:0] a;
        logic [7:0] c;
        a = e[15:8];
        c = e[7:0];
        return {8'hFF - c, c, 8'hFF - a, a};
    endfunction

    task automatic model_reset();
        q.delete();
        inflight   = 1'b0;
        seen_busy  = 1'b0;
        earliest   = 0;
        last_frame = '0;
        rise       = 0;
        fall       = 0;
        start_exp  = 1'b0;
        to_exp     = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_idle;
        exp_idle = !inflight && (t >= earliest - 1) && (q.size() == 0);
        check("tx_start", 32'(tx_start), 32'(start_exp));
        check("tx_data", tx_data, last_frame);
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("cmd_ready", 32'(cmd_ready), 32'(!reset && (q.size() < 4)));
        check("err_timeout", 32'(err_timeout), 32'(to_exp));
        check("idle", 32'(idle), 32'(exp_idle));
    endtask

    // One clock: model the edge from the inputs presented before it, then compare.
    task automatic step();
        bit          busy_s;
        bit          v;
        bit          acc;
        logic [15:0] ent;
        busy_s = tx_busy;
        v      = cmd_valid;
        ent    = {cmd_addr, cmd_code};
        @(posedge clock);
        t++;
        start_exp = 1'b0;
        to_exp    = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            acc = v && (q.size() < 4);
            if (inflight) begin
                if (!seen_busy) begin
                    if (busy_s && t >= s0 + 2 && t <= s0 + 1 + BT) begin
                        seen_busy = 1'b1;
                    end else if (t == s0 + 1 + BT) begin
                        to_exp   = 1'b1;
                        inflight = 1'b0;
                        earliest = t + GAP + 1;
                    end
                end else if (!busy_s) begin
                    inflight = 1'b0;
                    earliest = t + GAP + 1;
                    fall_edges.push_back(t);
                end
            end else if (q.size() > 0 && !busy_s && t >= earliest) begin
                last_frame = frame(q.pop_front());
                start_exp  = 1'b1;
                inflight   = 1'b1;
                seen_busy  = 1'b0;
                s0         = t;
                if (busy_mode == 1) begin
                    rise = t + 1 + busy_d;
                    fall = rise + busy_l;
                end
            end
            if (acc) q.push_back(ent);
        end
        #1;
        check_outputs();
        if (tx_start) begin
            dut_start_edges.push_back(t);
            dut_frames.push_back(tx_data);
        end
        if (err_timeout) dut_err_edges.push_back(t);
        if (idle && !prev_idle) dut_idle_rise.push_back(t);
        prev_idle = idle;
        tx_busy = (busy_mode == 2) || (busy_mode == 1 && (t + 1) >= rise && (t + 1) < fall);
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_code  = c;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic clear_logs();
        fall_edges.delete();
        dut_start_edges.delete();
        dut_err_edges.delete();
        dut_idle_rise.delete();
        dut_frames.delete();
    endtask

    // Reset asserted between clock edges must take effect without waiting for a clock.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        tx_busy = 1'b0;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_code  = '0;
        tx_busy   = 1'b0;
        busy_mode = 1;
        busy_d    = 2;
        busy_l    = 20;
        prev_idle = 1'b1;
        t         = 0;
        s0        = 0;
        model_reset();
        #1;
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_ready", 32'(cmd_ready), 32'd0);
        repeat (3) step();
        release_reset();

        // Single command: latency and frame layout.
        clear_logs();
        push_one(8'h00, 8'h45);
        step();
        check("lat_start_k1", 32'(tx_start), 32'd1);
        check("lat_frame", tx_data, 32'hBA45FF00);
        step();
        check("lat_start_k2", 32'(tx_start), 32'd0);
        repeat (50) step();

        // Busy held high: queue fills to four, fifth is refused, nothing starts.
        busy_mode = 2;
        tx_busy   = 1'b1;
        clear_logs();
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_addr = 8'(8'h40 + i);
            cmd_code = 8'(8'h80 + i);
            step();
        end
        step();
        cmd_valid = 1'b0;
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_no_start", 32'(dut_start_edges.size()), 32'd0);
        busy_mode = 1;
        rise = 0;
        fall = 0;
        tx_busy = 1'b0;
        repeat (160) step();
        check("drain_frames", 32'(dut_frames.size()), 32'd4);
        check("drain_idle", 32'(idle), 32'd1);

        // Two frames: contents and the gap after busy falls.
        clear_logs();
        push_one(8'h01, 8'h10);
        push_one(8'h02, 8'h20);
        repeat (80) step();
        check("pair_count", 32'(dut_frames.size()), 32'd2);
        if (dut_frames.size() == 2 && fall_edges.size() >= 1) begin
            check("pair_frame0", dut_frames[0], 32'hEF10FE01);
            check("pair_frame1", dut_frames[1], 32'hDF20FD02);
            check("pair_gap", 32'(dut_start_edges[1] - fall_edges[0]), 32'(GAP + 1));
        end

        // No busy response: timeout pulse, gap, then idle.
        busy_mode = 0;
        clear_logs();
        push_one(8'h5A, 8'hC3);
        repeat (40) step();
        check("to_pulses", 32'(dut_err_edges.size()), 32'd1);
        if (dut_err_edges.size() == 1 && dut_start_edges.size() == 1 && dut_idle_rise.size() >= 1) begin
            check("to_delay", 32'(dut_err_edges[0] - dut_start_edges[0]), 32'(BT + 1));
            check("to_gap_idle", 32'(dut_idle_rise[0] - dut_err_edges[0]), 32'(GAP));
        end

        // Push coincident with pop at level 2 keeps the level and the order.
        busy_mode = 2;
        tx_busy   = 1'b1;
        clear_logs();
        push_one(8'h11, 8'h22);
        push_one(8'h33, 8'h44);
        busy_mode = 1;
        rise = 0;
        fall = 0;
        tx_busy = 1'b0;
        push_one(8'h55, 8'h66);
        check("coinc_level", 32'(fifo_level), 32'd2);
        check("coinc_start", 32'(tx_start), 32'd1);
        repeat (120) step();
        check("coinc_count", 32'(dut_frames.size()), 32'd3);
        if (dut_frames.size() == 3) begin
            check("coinc_f0", dut_frames[0], 32'hDD22EE11);
            check("coinc_f1", dut_frames[1], 32'hBB44CC33);
            check("coinc_f2", dut_frames[2], 32'h9966AA55);
        end

        // Reset while SENDING with three queued: abort and stay quiet afterwards.
        clear_logs();
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_addr = 8'(8'hA0 + i);
            cmd_code = 8'(8'h0F + i);
            step();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && !(inflight && seen_busy); i++) step();
        check("abort_in_sending", 32'(inflight && seen_busy), 32'd1);
        check("abort_queued", 32'(fifo_level), 32'd3);
        mid_reset();
        step();
        release_reset();
        clear_logs();
        repeat (40) step();
        check("abort_no_restart", 32'(dut_start_edges.size()), 32'd0);

        // Random traffic with random busy timing and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_addr  = 8'($urandom);
            cmd_code  = 8'($urandom);
            busy_d    = $urandom_range(1, 20);
            busy_l    = $urandom_range(1, 20);
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
                step();
                release_reset();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
